// File: rtl/tf_spi_pkg.sv
// Shared types for the TF card SPI engine.
package tf_spi_pkg;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, FIN} tf_spi_state_t;

  localparam int unsigned DIV_W_DEFAULT = 8;

endpackage

// File: rtl/tf_spi_tick.sv
// Loadable half-period down-counter; expire is high while the count sits at zero.
module tf_spi_tick
  import tf_spi_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] value,
  output logic             expire
);

  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/tf_spi_engine.sv
// Byte-wide SPI master (mode 0, MSB first) for the TF card slot, with slow and fast SCK rates.
module tf_spi_engine
  import tf_spi_pkg::*;
#(
  parameter int unsigned DIV_SLOW = 34,
  parameter int unsigned DIV_FAST = 1,
  parameter int unsigned DIV_W    = DIV_W_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       fast,
  input  logic       cs_req,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_n
);

  localparam logic [DIV_W-1:0] RELOAD_SLOW = DIV_W'(DIV_SLOW - 1);
  localparam logic [DIV_W-1:0] RELOAD_FAST = DIV_W'(DIV_FAST - 1);

  tf_spi_state_t    state_q, state_d;
  logic             expire, load, accept, shift, last_bit;
  logic [DIV_W-1:0] reload;
  logic             fast_q;
  logic [6:0]       sr_q;
  logic [7:0]       rx_q;
  logic [2:0]       bit_q;
  logic             sck_q, mosi_q, cs_n_q;

  assign last_bit = (bit_q == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOW;
      LOW:     if (expire) state_d = HIGH;
      HIGH:    if (expire) state_d = last_bit ? FIN : LOW;
      FIN:     state_d = start ? LOW : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    accept = 1'b0;
    shift  = 1'b0;
    unique case (state_q)
      IDLE: accept = start;
      LOW:  busy = 1'b1;
      HIGH: begin
        busy  = 1'b1;
        shift = expire;
      end
      FIN: begin
        done   = 1'b1;
        accept = start;
      end
      default: ;
    endcase
  end

  // On accept the rate comes straight from the input, since fast_q is captured on the same edge.
  assign load   = accept | (busy & expire);
  assign reload = (accept ? fast : fast_q) ? RELOAD_FAST : RELOAD_SLOW;

  tf_spi_tick #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .value (reload),
    .expire(expire)
  );

  // sr_q holds the untransmitted tail of the TX byte; MISO bits enter from the bottom.
  always_ff @(posedge clk) begin
    if (reset) begin
      fast_q <= 1'b0;
      sr_q   <= '0;
      rx_q   <= '0;
      bit_q  <= '0;
      sck_q  <= 1'b0;
      mosi_q <= 1'b1;
      cs_n_q <= 1'b1;
    end else begin
      sck_q <= (state_d == HIGH);
      if (state_q == IDLE || state_q == FIN) begin
        cs_n_q <= ~cs_req;
      end
      if (accept) begin
        fast_q <= fast;
        sr_q   <= tx_data[6:0];
        mosi_q <= tx_data[7];
      end else if (shift) begin
        sr_q   <= {sr_q[5:0], spi_miso};
        bit_q  <= bit_q + 3'd1;
        mosi_q <= last_bit ? 1'b1 : sr_q[6];
        if (last_bit) begin
          rx_q <= {sr_q, spi_miso};
        end
      end
    end
  end

  assign rx_data  = rx_q;
  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_tf_spi_engine.sv
// Self-checking bench for tf_spi_engine: a slave model feeds MISO, pin timing derived arithmetically.
module tb_tf_spi_engine;

  localparam int unsigned DIV_SLOW = 34;
  localparam int unsigned DIV_FAST = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] tx_data;
  logic       fast;
  logic       cs_req;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_cs_n;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] rx_model = 8'h00;

  tf_spi_engine #(
    .DIV_SLOW(DIV_SLOW),
    .DIV_FAST(DIV_FAST),
    .DIV_W   (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .tx_data (tx_data),
    .fast    (fast),
    .cs_req  (cs_req),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .spi_sck (spi_sck),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called in cycle 0 (1 time unit after a rising edge). Returns in the FIN cycle when chaining,
  // otherwise one cycle later in IDLE.
  task automatic run_byte(input logic [7:0] tx, input logic [7:0] sl, input logic f,
                          input logic chain, input logic mid_chg, input logic cs_mid);
    int   d, last, bad, cs_bad, done_at, k, half;
    logic prev_sck, cs_exp, cs_fin;
    d        = f ? DIV_FAST : DIV_SLOW;
    last     = 16 * d + 1;
    start    = 1'b1;
    tx_data  = tx;
    fast     = f;
    spi_miso = sl[7];
    cs_exp   = ~cs_req;
    k        = 0;
    prev_sck = 1'b0;
    bad      = 0;
    cs_bad   = 0;
    done_at  = 0;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      #1;
      if (c < last) begin
        half = (c - 1) / d;
        if (spi_sck !== half[0] || spi_mosi !== tx[7 - half / 2] || busy !== 1'b1 ||
            done !== 1'b0 || rx_data !== rx_model) bad++;
      end
      if (spi_cs_n !== cs_exp) cs_bad++;
      if (done === 1'b1 && done_at == 0) done_at = c;
      if (prev_sck === 1'b1 && spi_sck === 1'b0) k++;
      prev_sck = spi_sck;
      if (k < 8) spi_miso = sl[7 - k];
      if (c == 1) start = chain;
      if (mid_chg && c == 3) begin
        start   = 1'b1;
        tx_data = 8'h00;
        fast    = ~f;
      end
      if (mid_chg && c == 4) start = chain;
      if (c == 6) cs_req = cs_mid;
    end
    check_eq("pins", bad, 0);
    check_eq("cs_hold", cs_bad, 0);
    check_eq("done_at", done_at, last);
    check_eq("fin_busy", busy, 1'b0);
    check_eq("fin_sck", spi_sck, 1'b0);
    check_eq("fin_mosi", spi_mosi, 1'b1);
    check_eq("rx", rx_data, sl);
    rx_model = sl;
    if (!chain) begin
      cs_fin = ~cs_req;
      @(posedge clk);
      #1;
      check_eq("idle_done", done, 1'b0);
      check_eq("idle_busy", busy, 1'b0);
      check_eq("cs_follow", spi_cs_n, cs_fin);
    end
  endtask

  initial begin
    int n_done;
    reset    = 1'b1;
    start    = 1'b0;
    tx_data  = 8'h00;
    fast     = 1'b0;
    cs_req   = 1'b0;
    spi_miso = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_rx", rx_data, 8'h00);
    check_eq("rst_sck", spi_sck, 1'b0);
    check_eq("rst_mosi", spi_mosi, 1'b1);
    check_eq("rst_cs", spi_cs_n, 1'b1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fast byte A5 against slave byte 3C, then a slow byte.
    cs_req = 1'b1;
    run_byte(8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    run_byte(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);

    // START and TX_DATA disturbed mid-byte; CS_REQ dropped at cycle 6.
    run_byte(8'hC3, 8'h96, 1'b1, 1'b0, 1'b1, 1'b0);
    cs_req = 1'b1;
    run_byte(8'h5E, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);

    // START held high: back-to-back bytes.
    cs_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_byte(8'($urandom), 8'($urandom), 1'b1, (i != 3), 1'b0, 1'b1);
    end

    // Power-up dummy clocks.
    cs_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      run_byte(8'hFF, 8'hFF, 1'b0, (i != 9), 1'b0, 1'b0);
    end

    // Reset mid-byte at cycle 5.
    cs_req  = 1'b1;
    tx_data = 8'h5A;
    fast    = 1'b1;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_done", done, 1'b0);
    check_eq("mid_rst_rx", rx_data, 8'h00);
    check_eq("mid_rst_sck", spi_sck, 1'b0);
    check_eq("mid_rst_mosi", spi_mosi, 1'b1);
    check_eq("mid_rst_cs", spi_cs_n, 1'b1);
    rx_model = 8'h00;
    n_done   = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n_done++;
    end
    check_eq("mid_rst_no_done", n_done, 0);

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      logic f, ch, mc, cm;
      f  = ($urandom_range(0, 3) != 0);
      ch = (i != 23) && ($urandom_range(0, 2) == 0);
      mc = $urandom_range(0, 1);
      cm = $urandom_range(0, 1);
      cs_req = $urandom_range(0, 1);
      run_byte(8'($urandom), 8'($urandom), f, ch, mc, cm);
      if (!ch) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
